// File: rtl/return_stack.sv
// return_stack: fixed-depth call/return-address LIFO with sticky
// overflow/underflow flags and an occupancy count. top_data is a
// combinational read of the registered top entry (zero read latency).
module return_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_push,
  input  logic             stack_pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             stack_overflow,
  output logic             stack_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_idx  = AW'(count_q - CW'(1));

  // Next-state decode of count, flags and the storage write for each push/pop combination
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    wr_idx  = count_q[AW-1:0];
    unique case ({stack_push, stack_pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          wr_idx  = count_q[AW-1:0];
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (is_empty) unf_d = 1'b1;
        else          count_d = count_q - CW'(1);
      end
      2'b11: begin
        // Simultaneous push+pop: replace the top entry, or behave as a
        // plain push (still flagging underflow) when nothing was there to pop.
        we = 1'b1;
        if (is_empty) begin
          wr_idx  = '0;
          count_d = CW'(1);
          unf_d   = 1'b1;
        end else begin
          wr_idx  = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and sticky flags; reset overrides any push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; never cleared, only entries below count are ever visible
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_idx] <= push_data;
  end

  assign top_data        = is_empty ? '0 : mem[top_idx];
  assign count           = count_q;
  assign empty           = is_empty;
  assign full            = is_full;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
